// File: rtl/seg7_scan_x4.sv
// seg7_scan_x4 -- time-multiplexed driver for a 4-digit 7-segment display.
//
// Scans one digit per slot of SCAN_DIV cycles, rightmost digit first. The
// first GUARD cycles of every slot keep everything dark so the previous
// digit's segments cannot ghost onto the newly selected anode. Digit values,
// decimal points and the leading-zero flag are snapshotted once per frame
// (four slots), so a counter rolling over mid-scan never shows mixed digits.
//
// Parameters:
//   SCAN_DIV   clock cycles per digit slot (>= 4)
//   GUARD      dark cycles at the start of each slot (1 <= GUARD < SCAN_DIV)
//   ACTIVE_LOW 1 = anodes, segments and dp driven active-low; 0 = active-high
//
// Ports:
//   clkIn          in   system clock
//   resetIn        in   synchronous reset, active-high
//   digitsIn[15:0] in   digit k in bits [4k+3:4k]; digit0 is rightmost
//   dpIn[3:0]      in   decimal point enable, bit k = digit k
//   blankLeadingIn in   1 = suppress leading zeros (digit0 always shown)
//   segmentsOut[6:0] out segment drive, bit0 = a .. bit6 = g
//   dpOut          out  decimal point drive
//   anodesOut[3:0] out  digit select, bit k = digit k
//   frameOut       out  one-cycle pulse in the first cycle of each frame
//
// All outputs are registered.
module seg7_scan_x4 #(
    parameter int SCAN_DIV   = 27000,
    parameter int GUARD      = 2700,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clkIn,
    input  logic        resetIn,
    input  logic [15:0] digitsIn,
    input  logic [3:0]  dpIn,
    input  logic        blankLeadingIn,
    output logic [6:0]  segmentsOut,
    output logic        dpOut,
    output logic [3:0]  anodesOut,
    output logic        frameOut
);

    localparam int            CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          POL      = (ACTIVE_LOW != 0);

    // cnt/idx name the position of the cycle that the NEXT edge starts; the
    // registered outputs for that cycle are computed from them on that edge.
    // After reset they are 0, so the first edge with resetIn low launches
    // frame 0, slot 0, offset 0 without any extra start-up state.
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   digitsSnap;
    logic [3:0]    dpSnap;
    logic          blankSnap;

    logic          frameStart;
    logic          cntLast;
    logic          showSlot;
    logic [3:0]    curDigit;
    logic          lead3;
    logic          lead2;
    logic          lead1;
    logic          blanked;
    logic [3:0]    anodeLogic;
    logic [6:0]    segLogic;
    logic          dpLogic;

    function automatic logic [6:0] glyphOf(input logic [3:0] v);
        glyphOf = 7'h00;
        case (v)
            4'h0: glyphOf = 7'h3F;
            4'h1: glyphOf = 7'h06;
            4'h2: glyphOf = 7'h5B;
            4'h3: glyphOf = 7'h4F;
            4'h4: glyphOf = 7'h66;
            4'h5: glyphOf = 7'h6D;
            4'h6: glyphOf = 7'h7D;
            4'h7: glyphOf = 7'h07;
            4'h8: glyphOf = 7'h7F;
            4'h9: glyphOf = 7'h6F;
            4'hA: glyphOf = 7'h77;
            4'hB: glyphOf = 7'h7C;
            4'hC: glyphOf = 7'h39;
            4'hD: glyphOf = 7'h5E;
            4'hE: glyphOf = 7'h79;
            4'hF: glyphOf = 7'h71;
        endcase
    endfunction

    always_comb begin
        frameStart = (cnt == '0) && (idx == 2'd0);
        cntLast    = (cnt == CNT_LAST);
        showSlot   = (cnt >= GUARD_C);
        curDigit   = digitsSnap[{idx, 2'b00} +: 4];

        // A digit is blanked only if it and every digit to its left are zero.
        lead3 = blankSnap && (digitsSnap[15:12] == 4'h0);
        lead2 = lead3 && (digitsSnap[11:8] == 4'h0);
        lead1 = lead2 && (digitsSnap[7:4] == 4'h0);

        blanked = 1'b0;
        case (idx)
            2'd3: blanked = lead3;
            2'd2: blanked = lead2;
            2'd1: blanked = lead1;
            default: blanked = 1'b0;
        endcase

        // Frame-start cycles are always inside the guard (GUARD >= 1), so the
        // snapshot taken on that edge is in place before any show cycle.
        anodeLogic = 4'b0000;
        segLogic   = 7'h00;
        dpLogic    = 1'b0;
        if (showSlot && !blanked) begin
            anodeLogic[idx] = 1'b1;
            segLogic        = glyphOf(curDigit);
            dpLogic         = dpSnap[idx];
        end
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            cnt         <= '0;
            idx         <= 2'd0;
            digitsSnap  <= 16'h0000;
            dpSnap      <= 4'h0;
            blankSnap   <= 1'b0;
            anodesOut   <= {4{POL}};
            segmentsOut <= {7{POL}};
            dpOut       <= POL;
            frameOut    <= 1'b0;
        end else begin
            if (frameStart) begin
                digitsSnap <= digitsIn;
                dpSnap     <= dpIn;
                blankSnap  <= blankLeadingIn;
            end
            if (cntLast) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
            anodesOut   <= anodeLogic ^ {4{POL}};
            segmentsOut <= segLogic ^ {7{POL}};
            dpOut       <= dpLogic ^ POL;
            frameOut    <= frameStart;
        end
    end

endmodule

// File: tb/tb_seg7_scan_x4.sv
// Bench for seg7_scan_x4 with SCAN_DIV=8, GUARD=2, ACTIVE_LOW=1.
// A cycle-indexed reference model pushes the expected physical outputs
// {anodes, segments, dp, frame} into exp_q for each clock; every test task
// pops and compares after the edge, plus a few hand-written constant checks.
module tb_seg7_scan_x4;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FL = 4 * SD;
    localparam logic [6:0] GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        resetIn = 1'b1;
    logic [15:0] digitsIn = 16'h0000;
    logic [3:0]  dpIn = 4'h0;
    logic        blankLeadingIn = 1'b0;
    logic [6:0]  segmentsOut;
    logic        dpOut;
    logic [3:0]  anodesOut;
    logic        frameOut;

    logic [12:0] dut_out;
    assign dut_out = {anodesOut, segmentsOut, dpOut, frameOut};

    logic [12:0] exp_q[$];
    logic [12:0] exp_v;
    int          vectors = 0;
    int          miscompares = 0;

    // reference model state
    int          mdl_n = 0;
    logic [15:0] mdl_dig = '0;
    logic [3:0]  mdl_dp = '0;
    logic        mdl_blank = 1'b0;

    seg7_scan_x4 #(.SCAN_DIV(SD), .GUARD(GD), .ACTIVE_LOW(1)) dut (
        .clkIn(clk),
        .resetIn(resetIn),
        .digitsIn(digitsIn),
        .dpIn(dpIn),
        .blankLeadingIn(blankLeadingIn),
        .segmentsOut(segmentsOut),
        .dpOut(dpOut),
        .anodesOut(anodesOut),
        .frameOut(frameOut)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Driver: predicts the cycle the next edge starts from the inputs present
    // now, queues it, then advances to 1 time unit past that edge.
    task automatic drive_cycle();
        logic [3:0] an;
        logic [6:0] sg;
        logic       dl;
        logic       fr;
        int         slot;
        int         off;
        logic [3:0] d;
        logic       blk;
        if (resetIn) begin
            exp_v = {4'hF, 7'h7F, 1'b1, 1'b0};
            mdl_n = 0;
        end else begin
            if (mdl_n % FL == 0) begin
                mdl_dig   = digitsIn;
                mdl_dp    = dpIn;
                mdl_blank = blankLeadingIn;
            end
            slot = (mdl_n % FL) / SD;
            off  = mdl_n % SD;
            fr   = (mdl_n % FL == 0);
            d    = mdl_dig[slot*4 +: 4];
            blk  = mdl_blank && (slot > 0) && ((mdl_dig >> (4 * slot)) == 16'h0);
            an = 4'h0;
            sg = 7'h00;
            dl = 1'b0;
            if (off >= GD && !blk) begin
                an = 4'b0001 << slot;
                sg = GLYPH[d];
                dl = mdl_dp[slot];
            end
            exp_v = {~an, ~sg, ~dl, fr};
            mdl_n++;
        end
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        logic [12:0] e;
        resetIn = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL reset_hold got=%h exp=%h", dut_out, e);
            end
        end
        resetIn = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        resetIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL reset got=%h exp=%h", dut_out, e);
            end
            vectors++;
            if (anodesOut !== 4'b1111 || segmentsOut !== 7'h7F || dpOut !== 1'b1 || frameOut !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_const an=%b seg=%h dp=%b fr=%b exp an=1111 seg=7f dp=1 fr=0",
                         anodesOut, segmentsOut, dpOut, frameOut);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [12:0] e;
        digitsIn = 16'h1234; dpIn = 4'h0; blankLeadingIn = 1'b0;
        do_reset(1);
        for (int c = 0; c <= 64; c++) begin
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, dut_out, e);
            end
            if (c == 0 || c == 32 || c == 64 || c == 1 || c == 33) begin
                vectors++;
                if (frameOut !== ((c % 32) == 0)) begin
                    miscompares++;
                    $display("FAIL basic_frame c=%0d got=%b", c, frameOut);
                end
            end
            if (c == 2 || c == 7) begin
                vectors++;
                if (anodesOut !== 4'b1110 || segmentsOut !== ~7'h66) begin
                    miscompares++;
                    $display("FAIL basic_d0 c=%0d an=%b seg=%h exp an=1110 seg=19", c, anodesOut, segmentsOut);
                end
            end
            if (c == 26) begin
                vectors++;
                if (anodesOut !== 4'b0111 || segmentsOut !== ~7'h06) begin
                    miscompares++;
                    $display("FAIL basic_d3 an=%b seg=%h exp an=0111 seg=79", anodesOut, segmentsOut);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [12:0] e;
        digitsIn = 16'h1111;
        do_reset(1);
        for (int c = 0; c < 40; c++) begin
            if (c == 10) digitsIn = 16'h2222;
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL snapshot c=%0d got=%h exp=%h", c, dut_out, e);
            end
            if (c == 12 || c == 30) begin
                vectors++;
                if (segmentsOut !== ~7'h06) begin
                    miscompares++;
                    $display("FAIL snap_old c=%0d seg=%h exp=79", c, segmentsOut);
                end
            end
            if (c == 34) begin
                vectors++;
                if (segmentsOut !== ~7'h5B) begin
                    miscompares++;
                    $display("FAIL snap_new seg=%h exp=24", segmentsOut);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [12:0] e;
        logic [15:0] pats [3] = '{16'h0007, 16'h0100, 16'h0000};
        logic [3:0]  seen;
        logic [3:0]  want [3] = '{4'b0001, 4'b0111, 4'b0001};
        blankLeadingIn = 1'b1;
        for (int p = 0; p < 3; p++) begin
            digitsIn = pats[p];
            do_reset(1);
            seen = 4'h0;
            for (int c = 0; c < FL; c++) begin
                drive_cycle();
                seen = seen | ~anodesOut;
                e = exp_q.pop_front();
                vectors++;
                if (dut_out !== e) begin
                    miscompares++;
                    $display("FAIL blank p=%0d c=%0d got=%h exp=%h", p, c, dut_out, e);
                end
            end
            vectors++;
            if (seen !== want[p]) begin
                miscompares++;
                $display("FAIL blank_anodes p=%0d seen=%b exp=%b", p, seen, want[p]);
            end
        end
        blankLeadingIn = 1'b0;
    endtask

    task automatic test_hex_dp();
        logic [12:0] e;
        int          dp_on;
        digitsIn = 16'hABCD; dpIn = 4'b0010;
        do_reset(1);
        dp_on = 0;
        for (int c = 0; c < FL; c++) begin
            drive_cycle();
            if (dpOut === 1'b0) dp_on++;
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL hex c=%0d got=%h exp=%h", c, dut_out, e);
            end
            if (c == 4) begin
                vectors++;
                if (segmentsOut !== ~7'h5E) begin
                    miscompares++;
                    $display("FAIL hex_d seg=%h exp=21", segmentsOut);
                end
            end
        end
        vectors++;
        if (dp_on !== SD - GD) begin
            miscompares++;
            $display("FAIL dp_cycles got=%0d exp=%0d", dp_on, SD - GD);
        end
        dpIn = 4'h0;
    endtask

    task automatic test_midframe_reset();
        logic [12:0] e;
        digitsIn = 16'h1234;
        do_reset(1);
        for (int c = 0; c < 13; c++) begin
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL mid_pre c=%0d got=%h exp=%h", c, dut_out, e);
            end
        end
        do_reset(1);
        vectors++;
        if (dut_out !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset got=%h exp=1ffe", dut_out);
        end
        for (int c = 0; c < 10; c++) begin
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL mid_post c=%0d got=%h exp=%h", c, dut_out, e);
            end
            if (c == 0) begin
                vectors++;
                if (frameOut !== 1'b1) begin
                    miscompares++;
                    $display("FAIL mid_frame got=%b exp=1", frameOut);
                end
            end
            if (c == 3) begin
                vectors++;
                if (anodesOut !== 4'b1110) begin
                    miscompares++;
                    $display("FAIL mid_d0 an=%b exp=1110", anodesOut);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] e;
        do_reset(1);
        for (int c = 0; c < 3 * FL; c++) begin
            digitsIn       = 16'($urandom_range(0, 65535));
            dpIn           = 4'($urandom_range(0, 15));
            blankLeadingIn = 1'($urandom_range(0, 1));
            if (c % 7 == 3) digitsIn[15:8] = 8'h00;
            drive_cycle();
            e = exp_q.pop_front();
            vectors++;
            if (dut_out !== e) begin
                miscompares++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_out, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_snapshot();
        test_blanking();
        test_hex_dp();
        test_midframe_reset();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_leftover size=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
